// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types, mode constants and sizing helper for the
//               sequential shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MU_UNSIGNED = 1'b1;
  localparam logic MU_SIGNED   = 1'b0;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/twos_negate.sv
// ============================================================================
// Module      : twos_negate
// Description : Conditional two's-complement negation, y = en ? -x : x.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? ((~x) + W'(1)) : x;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : Multi-cycle signed/unsigned shift-add multiplier with a
//               start/busy/done handshake and a 2*WIDTH-bit HI/LO result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             MU,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int c_cnt_w = clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_high;
  logic [WIDTH-1:0]     r_low;

  logic                 w_signed;
  logic                 w_last;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod_fix;

  assign w_signed = (MU == MU_SIGNED);
  assign w_last   = (r_cnt == c_cnt_w'(WIDTH - 1));

  // The most negative operand negates to itself, which read unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  twos_negate #(.W(WIDTH)) u_neg_a (
    .en (w_signed & a[WIDTH-1]),
    .x  (a),
    .y  (w_abs_a)
  );

  twos_negate #(.W(WIDTH)) u_neg_b (
    .en (w_signed & b[WIDTH-1]),
    .x  (b),
    .y  (w_abs_b)
  );

  twos_negate #(.W(2*WIDTH)) u_neg_p (
    .en (r_neg),
    .x  (r_acc),
    .y  (w_prod_fix)
  );

  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = SIGN;
      end
      SIGN: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? CALC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_high   <= '0;
      r_low    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          // Carry out of the upper-half add re-enters as the new MSB.
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_cnt_w'(1);
        end
        SIGN: begin
          r_acc  <= w_prod_fix;
          r_high <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_low  <= w_prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign high = r_high;
  assign low  = r_low;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier at WIDTH=32 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0, mu32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] high32, low32;

  logic        start8 = 1'b0, mu8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  high8, low8;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) u_dut32 (
    .clk (clk), .rst (rst), .start (start32), .MU (mu32), .a (a32), .b (b32),
    .busy (busy32), .done (done32), .high (high32), .low (low32)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (start8), .MU (mu8), .a (a8), .b (b8),
    .busy (busy8), .done (done8), .high (high8), .low (low8)
  );

  // Golden product: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic mu,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [127:0] sa, sb, p;
    logic [31:0]  mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    sa = 128'(a & mask);
    sb = 128'(b & mask);
    if (!mu && a[w-1]) sa = sa - (128'd1 << w);
    if (!mu && b[w-1]) sb = sb - (128'd1 << w);
    p = sa * sb;
    return (w == 32) ? p[63:0] : {48'd0, p[15:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: an accepted start at edge 0 means busy for w+1
  // cycles, then one done cycle in which the new result is visible.
  bit          m_act [2];
  int          m_n   [2];
  logic [63:0] m_prod[2];
  logic [63:0] m_held[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          w;
      logic        st, mu;
      logic [31:0] av, bv;
      w  = (d == 0) ? 32 : 8;
      st = (d == 0) ? start32 : start8;
      mu = (d == 0) ? mu32 : mu8;
      av = (d == 0) ? a32 : {24'd0, a8};
      bv = (d == 0) ? b32 : {24'd0, b8};
      if (rst) begin
        m_act[d]  = 1'b0;
        m_n[d]    = 0;
        m_held[d] = '0;
      end else if ((!m_act[d] || m_n[d] == w + 1) && st) begin
        m_act[d]  = 1'b1;
        m_n[d]    = 0;
        m_prod[d] = ref_prod(w, mu, av, bv);
      end else if (m_act[d]) begin
        m_n[d]++;
        if (m_n[d] == w + 1) m_held[d] = m_prod[d];
        if (m_n[d] > w + 1)  m_act[d]  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int w;
        w = (d == 0) ? 32 : 8;
        check($sformatf("busy%0d", w), (d == 0) ? busy32 : busy8,
              m_act[d] && m_n[d] <= w);
        check($sformatf("done%0d", w), (d == 0) ? done32 : done8,
              m_act[d] && m_n[d] == w + 1);
        check($sformatf("result%0d", w),
              (d == 0) ? {high32, low32} : {48'd0, high8, low8}, m_held[d]);
      end
    end
  end

  task automatic issue32(input logic mu, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; mu32 = mu; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait32(input string nm, input int c0, input logic [31:0] eh, input logic [31:0] el);
    int c;
    c = c0;
    while (!done32 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_latency"}, c, 34);
    check({nm, "_high"}, high32, eh);
    check({nm, "_low"}, low32, el);
  endtask

  task automatic run8(input string nm, input logic mu, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int c;
    start8 = 1'b1; mu8 = mu; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    c = 1;
    while (!done8 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_latency"}, c, 10);
    check({nm, "_prod"}, {high8, low8}, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", busy32, 1'b0);
    check("reset_done", done32, 1'b0);
    check("reset_result", {high32, low32}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue32(1'b1, 32'd7, 32'd6);
    wait32("u7x6", 1, 32'h0000_0000, 32'h0000_002A);
    @(negedge clk);
    issue32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32("u_max", 1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32("s_m1", 1, 32'h0000_0000, 32'h0000_0001);
    issue32(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait32("s_min2", 1, 32'h4000_0000, 32'h0000_0000);
    issue32(1'b0, 32'h8000_0000, 32'd1);
    wait32("s_minx1", 1, 32'hFFFF_FFFF, 32'h8000_0000);
    @(negedge clk);

    // Start while busy must be ignored; then restart from the DONE cycle.
    issue32(1'b1, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    issue32(1'b1, 32'd9, 32'd9);
    wait32("ignored", 10, 32'd0, 32'h0000_000F);
    issue32(1'b1, 32'd2, 32'd2);
    wait32("b2b", 1, 32'd0, 32'd4);

    // Mid-operation reset aborts without a done pulse.
    repeat (2) @(negedge clk);
    issue32(1'b1, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy32, 1'b0);
    check("abort_done", done32, 1'b0);
    check("abort_result", {high32, low32}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("abort_no_done", done32, 1'b0);
    end
    issue32(1'b1, 32'd6, 32'd7);
    wait32("after_abort", 1, 32'd0, 32'h0000_002A);
    @(negedge clk);

    run8("s8_min2", 1'b0, 8'h80, 8'h80, 16'h4000);
    run8("u8_max", 1'b1, 8'hFF, 8'hFF, 16'hFE01);
    run8("s8_m3x5", 1'b0, 8'hFD, 8'h05, 16'hFFF1);
    for (int i = 0; i < 1000; i++) begin
      logic        mu;
      logic [7:0]  ra, rb;
      mu = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      g  = ref_prod(8, mu, {24'd0, ra}, {24'd0, rb});
      run8("rand8", mu, ra, rb, g[15:0]);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
